mdr_unit: RTL and testbench
===========================

MDR_UNIT -- requirements
Module: mdr_unit

Interface
REQ-001 Parameter WIDTH, default 32: data width of every data port and of the MDR register.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles spent waiting for mem_ack, legal range 1..255.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset, asynchronous and active-low.
REQ-005 bus_in  input  WIDTH  value from the bus_mux output.
REQ-006 mdr_in  input  1  request strobe, sampled on the rising edge.
REQ-007 read  input  1  request source when mdr_in=1: 1=memory, 0=bus.
REQ-008 mem_data_in  input  WIDTH  memory read data; valid only in the cycle mem_ack=1.
REQ-009 mem_ack  input  1  memory read acknowledge, single-cycle pulse.
REQ-010 mem_req  output  1  memory read request, registered.
REQ-011 mdr_out  output  WIDTH  MDR contents, registered; feeds the bus_mux mdr input.
REQ-012 busy  output  1  high when not in IDLE.
REQ-013 done  output  1  one-cycle pulse on each completed load.
REQ-014 err  output  1  sticky memory-timeout flag.

Function
REQ-015 The block SHALL use a 2-state FSM: IDLE and WAIT_MEM.
REQ-016 IDLE, mdr_in=1, read=0: mdr_out SHALL take bus_in on that edge, done SHALL be 1 for the following cycle, and the state SHALL stay IDLE (bus load latency = 1 cycle).
REQ-017 IDLE, mdr_in=1, read=1: the block SHALL set mem_req=1, clear the wait counter to 0, clear err, and enter WAIT_MEM on that edge.
REQ-018 WAIT_MEM: mem_req SHALL stay 1 and the counter SHALL increment by 1 on each edge without mem_ack.
REQ-019 WAIT_MEM, mem_ack=1: mdr_out SHALL take mem_data_in, mem_req SHALL go 0, done SHALL pulse for one cycle, and the state SHALL return to IDLE on the same edge.
REQ-020 WAIT_MEM, counter=TIMEOUT-1, no mem_ack: mem_req SHALL go 0, err SHALL go 1, mdr_out SHALL be unchanged, done SHALL stay 0, and the state SHALL return to IDLE.
REQ-021 If mem_ack and the timeout edge coincide, the ack SHALL win: load, done=1, err=0.
REQ-022 mdr_in SHALL be ignored in WAIT_MEM; there is no queueing and no effect on mdr_out.
REQ-023 mem_ack SHALL be ignored in IDLE; mdr_out and done are unchanged.
REQ-024 A bus load in IDLE SHALL also clear err.
REQ-025 busy SHALL equal (state==WAIT_MEM), decoded from registered state.
REQ-026 done SHALL never be 1 on two consecutive cycles from a single request.
REQ-027 The counter SHALL be 8 bits wide and SHALL never wrap, because the timeout exits first.
REQ-028 A memory request SHALL complete within TIMEOUT edges after entering WAIT_MEM.

Reset
REQ-029 clear=0 SHALL immediately, without a clock, force state=IDLE, mdr_out=0, mem_req=0, done=0, err=0, and counter=0.
REQ-030 Reset asserted in WAIT_MEM SHALL abort the request: mem_req drops asynchronously and no done is issued.
REQ-031 A mem_ack arriving after the release of clear SHALL be ignored (covered by REQ-023).
REQ-032 The first request SHALL be accepted on the first rising edge with clear=1.

Verification
REQ-033 Bus load: bus_in=32'hDEADBEEF, mdr_in=1, read=0 for 1 cycle -> next cycle mdr_out=32'hDEADBEEF, done=1, busy=0; the cycle after that done=0.
REQ-034 Memory read: mdr_in=1, read=1; mem_ack=1 with mem_data_in=32'h12345678 on the 3rd WAIT_MEM edge -> mem_req high for 3 cycles, then mdr_out=32'h12345678, done=1, err=0.
REQ-035 Timeout: TIMEOUT=15, read request, no mem_ack -> mem_req high for exactly 15 cycles, then err=1, mdr_out unchanged, done=0; a following bus load clears err.
REQ-036 Collision: mem_ack on the 15th WAIT_MEM edge -> data loaded, done=1, err=0; a further mdr_in pulse during WAIT_MEM leaves mdr_out unchanged.
REQ-037 Async reset: clear=0 mid-WAIT_MEM between clock edges -> mem_req=0, mdr_out=0, busy=0 before the next edge; a stray mem_ack after release -> no change.

Source files
------------

// File: rtl/mdr_unit.sv
// Memory data register: loads from the bus in one cycle or from memory with a bounded ack wait.
// While a memory read is outstanding, new requests are dropped and no queueing occurs.
module mdr_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             mdr_in,
  input  logic             read,
  input  logic [WIDTH-1:0] mem_data_in,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [WIDTH-1:0] mdr_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] mdr_nxt;
  logic             req_nxt, done_nxt, err_nxt;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      mdr_out <= '0;
      mem_req <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mdr_out <= mdr_nxt;
      mem_req <= req_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdr_nxt   = mdr_out;
    req_nxt   = mem_req;
    done_nxt  = 1'b0;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (mdr_in) begin
          err_nxt = 1'b0;
          if (read) begin
            req_nxt   = 1'b1;
            cnt_nxt   = 8'd0;
            state_nxt = WAIT_MEM;
          end else begin
            mdr_nxt  = bus_in;
            done_nxt = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // An ack on the final wait edge takes priority over the timeout.
        if (mem_ack) begin
          mdr_nxt   = mem_data_in;
          req_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == WAIT_MEM);

endmodule

// File: tb/tb_mdr_unit.sv
// Directed bench for mdr_unit: bus load, memory read, timeout, ack/timeout collision, async reset.
module tb_mdr_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] bus_in;
  logic        mdr_in;
  logic        read;
  logic [31:0] mem_data_in;
  logic        mem_ack;
  logic        mem_req;
  logic [31:0] mdr_out;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int hi_cnt;

  mdr_unit #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clock      (clock),
    .clear      (clear),
    .bus_in     (bus_in),
    .mdr_in     (mdr_in),
    .read       (read),
    .mem_data_in(mem_data_in),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mdr_out    (mdr_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b0; bus_in = '0; mdr_in = 1'b0; read = 1'b0;
    mem_data_in = '0; mem_ack = 1'b0;
    #12;
    check("rst_mdr_out", mdr_out, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_busy",    {31'b0, busy}, 32'h0);
    check("rst_done",    {31'b0, done}, 32'h0);
    check("rst_err",     {31'b0, err}, 32'h0);

    // First edge after release accepts a bus load
    @(negedge clock);
    clear = 1'b1; bus_in = 32'hDEADBEEF; mdr_in = 1'b1; read = 1'b0;
    @(negedge clock);
    mdr_in = 1'b0;
    check("bus_mdr_out", mdr_out, 32'hDEADBEEF);
    check("bus_done",    {31'b0, done}, 32'h1);
    check("bus_busy",    {31'b0, busy}, 32'h0);
    @(negedge clock);
    check("bus_done_drop", {31'b0, done}, 32'h0);
    check("bus_mdr_hold",  mdr_out, 32'hDEADBEEF);

    // Memory read, ack on the third wait edge
    mdr_in = 1'b1; read = 1'b1;
    @(negedge clock);
    mdr_in = 1'b0; read = 1'b0;
    check("mem_req_e0", {31'b0, mem_req}, 32'h1);
    check("mem_busy_e0", {31'b0, busy}, 32'h1);
    @(negedge clock);
    check("mem_req_e1", {31'b0, mem_req}, 32'h1);
    @(negedge clock);
    check("mem_req_e2", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_data_in = 32'h12345678;
    @(negedge clock);
    mem_ack = 1'b0; mem_data_in = '0;
    check("mem_req_drop", {31'b0, mem_req}, 32'h0);
    check("mem_mdr_out",  mdr_out, 32'h12345678);
    check("mem_done",     {31'b0, done}, 32'h1);
    check("mem_err",      {31'b0, err}, 32'h0);
    check("mem_busy",     {31'b0, busy}, 32'h0);
    @(negedge clock);
    check("mem_done_drop", {31'b0, done}, 32'h0);

    // Timeout with no ack
    mdr_in = 1'b1; read = 1'b1;
    @(negedge clock);
    mdr_in = 1'b0; read = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      hi_cnt++;
      @(negedge clock);
    end
    check("to_req_cycles", hi_cnt, 32'd15);
    check("to_err",     {31'b0, err}, 32'h1);
    check("to_done",    {31'b0, done}, 32'h0);
    check("to_mdr_out", mdr_out, 32'h12345678);
    check("to_busy",    {31'b0, busy}, 32'h0);
    bus_in = 32'hA5A5A5A5; mdr_in = 1'b1; read = 1'b0;
    @(negedge clock);
    mdr_in = 1'b0;
    check("to_bus_err_clr", {31'b0, err}, 32'h0);
    check("to_bus_mdr",     mdr_out, 32'hA5A5A5A5);
    check("to_bus_done",    {31'b0, done}, 32'h1);

    // Ack on the 15th wait edge, with an ignored mdr_in pulse mid-wait
    mdr_in = 1'b1; read = 1'b1;
    @(negedge clock);
    mdr_in = 1'b0; read = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      if (i == 5) begin
        mdr_in = 1'b1; read = 1'b0; bus_in = 32'hFFFF0000;
      end else begin
        mdr_in = 1'b0;
      end
      if (i == 7) begin
        check("col_mdr_hold", mdr_out, 32'hA5A5A5A5);
        check("col_busy_mid", {31'b0, busy}, 32'h1);
      end
    end
    mem_ack = 1'b1; mem_data_in = 32'hCAFEF00D;
    @(negedge clock);
    mem_ack = 1'b0; mem_data_in = '0;
    check("col_mdr_out", mdr_out, 32'hCAFEF00D);
    check("col_done",    {31'b0, done}, 32'h1);
    check("col_err",     {31'b0, err}, 32'h0);
    check("col_busy",    {31'b0, busy}, 32'h0);

    // Asynchronous reset in the middle of a wait
    mdr_in = 1'b1; read = 1'b1;
    @(negedge clock);
    mdr_in = 1'b0; read = 1'b0;
    @(negedge clock);
    check("ar_busy_pre", {31'b0, busy}, 32'h1);
    #2 clear = 1'b0;
    #1;
    check("ar_mem_req", {31'b0, mem_req}, 32'h0);
    check("ar_mdr_out", mdr_out, 32'h0);
    check("ar_busy",    {31'b0, busy}, 32'h0);
    @(negedge clock);
    clear = 1'b1; mem_ack = 1'b1; mem_data_in = 32'h11111111;
    @(negedge clock);
    mem_ack = 1'b0; mem_data_in = '0;
    check("ar_stray_mdr",  mdr_out, 32'h0);
    check("ar_stray_done", {31'b0, done}, 32'h0);
    check("ar_stray_req",  {31'b0, mem_req}, 32'h0);
    check("ar_stray_busy", {31'b0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
